// File: rtl/status_frame_tx.sv
// status_frame_tx
// Builds 8-byte telemetry/ack frames (EB 90 CS AB B4 B5 09 D7) and pushes them
// one byte at a time into the UART TX FIFO. Two sources feed the sender: an
// acknowledge of an executed command and a free-running heartbeat.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | nothing in flight, waiting for ack_pend or hb_pend
//  LOAD   | snapshot CS/B4/B5 from pending source and status inputs
//  SEND   | push frame[idx] as soon as the FIFO has room
//  GAP    | one idle cycle so tf_counter reflects the last push
//  DONE   | pulse frame_done, then return to IDLE
module status_frame_tx #(
  parameter int unsigned PERIOD_CYC = 50_000_000,
  parameter int unsigned TF_DEPTH   = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ack_req,
  input  logic [7:0]       ack_code,
  input  logic             ack_err,
  input  logic             hb_en,
  input  logic             switch,
  input  logic             power_on_a,
  input  logic             power_on_b,
  input  logic             reset_a_signal,
  input  logic             reset_b_signal,
  input  logic [CNT_W-1:0] tf_counter,
  output logic             tf_push,
  output logic [7:0]       tdr,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned TMR_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(PERIOD_CYC - 1);

  localparam logic [7:0] FR_B0 = 8'hEB;
  localparam logic [7:0] FR_B1 = 8'h90;
  localparam logic [7:0] FR_B3 = 8'hAB;
  localparam logic [7:0] FR_B6 = 8'h09;
  localparam logic [7:0] FR_B7 = 8'hD7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q;
  logic [TMR_W-1:0] timer_q;
  logic             hb_tick;
  logic             ack_pend_q, hb_pend_q;
  logic [7:0]       ack_code_q;
  logic             ack_err_q;
  logic [7:0]       seq_q;
  logic [7:0]       cs_q, b4_q, b5_q;
  logic [7:0]       tdr_q;

  logic             load_ack;
  logic [7:0]       b4_d, b5_d, cs_d;
  logic [7:0]       cur_byte;
  logic             fifo_ok;
  logic             in_load;

  assign fifo_ok = (32'(tf_counter) < TF_DEPTH);
  assign hb_tick = hb_en && (timer_q == TMR_TC);
  assign in_load = (state_q == S_LOAD);

  // Frame fields that depend on the selected source and the live status lines;
  // only captured in LOAD, so later status changes never touch a frame in flight.
  always_comb begin
    load_ack = ack_pend_q;
    b4_d     = load_ack ? ack_code_q : seq_q;
    b5_d     = {switch, power_on_a, power_on_b, reset_a_signal, reset_b_signal,
                load_ack & ack_err_q, load_ack, 1'b0};
    cs_d     = 8'h00 - (FR_B3 + b4_d + b5_d);
  end

  // Byte selector: fixed header/trailer bytes come from constants, the rest
  // from the LOAD snapshot.
  always_comb begin
    cur_byte = FR_B0;
    case (idx_q)
      3'd0:    cur_byte = FR_B0;
      3'd1:    cur_byte = FR_B1;
      3'd2:    cur_byte = cs_q;
      3'd3:    cur_byte = FR_B3;
      3'd4:    cur_byte = b4_q;
      3'd5:    cur_byte = b5_q;
      3'd6:    cur_byte = FR_B6;
      default: cur_byte = FR_B7;
    endcase
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d    = state_q;
    tf_push    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ack_pend_q || hb_pend_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (fifo_ok) begin
          tf_push = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = (idx_q == 3'd7) ? S_DONE : S_SEND;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign tdr  = tf_push ? cur_byte : tdr_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Heartbeat timer: counts while enabled, wraps at the period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             timer_q <= '0;
    else if (!hb_en)        timer_q <= '0;
    else if (timer_q == TMR_TC) timer_q <= '0;
    else                    timer_q <= timer_q + 1'b1;
  end

  // Pending flags; a new request in the LOAD cycle wins over the clear so it is
  // not lost. A newer ack overwrites an unsent one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend_q <= 1'b0;
      ack_code_q <= '0;
      ack_err_q  <= 1'b0;
      hb_pend_q  <= 1'b0;
    end else begin
      if (ack_req) begin
        ack_pend_q <= 1'b1;
        ack_code_q <= ack_code;
        ack_err_q  <= ack_err;
      end else if (in_load && load_ack) begin
        ack_pend_q <= 1'b0;
      end
      if (hb_tick)                     hb_pend_q <= 1'b1;
      else if (in_load && !load_ack)   hb_pend_q <= 1'b0;
    end
  end

  // Frame snapshot, byte index and heartbeat sequence number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q  <= '0;
      b4_q  <= '0;
      b5_q  <= '0;
      idx_q <= '0;
      seq_q <= '0;
    end else if (in_load) begin
      cs_q  <= cs_d;
      b4_q  <= b4_d;
      b5_q  <= b5_d;
      idx_q <= '0;
      if (!load_ack) seq_q <= seq_q + 8'd1;
    end else if ((state_q == S_GAP) && (idx_q != 3'd7)) begin
      idx_q <= idx_q + 3'd1;
    end
  end

  // Holds the last pushed byte so tdr stays stable between pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tdr_q <= '0;
    else if (tf_push) tdr_q <= cur_byte;
  end

endmodule

// File: tb/tb_status_frame_tx.sv
// Bench for status_frame_tx: a frame-level model (expected byte queue built
// from the frame layout rules) checked against every push, plus directed
// literal checks on known frames and timings.
module tb_status_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ack_req = 1'b0;
  logic [7:0] ack_code = '0;
  logic       ack_err = 1'b0;
  logic       hb_en = 1'b0;
  logic       switch = 1'b0;
  logic       power_on_a = 1'b0;
  logic       power_on_b = 1'b0;
  logic       reset_a_signal = 1'b0;
  logic       reset_b_signal = 1'b0;
  logic [4:0] tf_counter = '0;
  logic       tf_push;
  logic [7:0] tdr;
  logic       busy;
  logic       frame_done;

  status_frame_tx #(.PERIOD_CYC(64), .TF_DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ack_req(ack_req), .ack_code(ack_code),
    .ack_err(ack_err), .hb_en(hb_en), .switch(switch), .power_on_a(power_on_a),
    .power_on_b(power_on_b), .reset_a_signal(reset_a_signal),
    .reset_b_signal(reset_b_signal), .tf_counter(tf_counter),
    .tf_push(tf_push), .tdr(tdr), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         push_cyc_q[$];
  int         done_cyc_q[$];
  int         push_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] seq_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame from the layout rules, using the status lines as they are now.
  function automatic void exp_frame(input bit is_ack, input logic [7:0] code, input bit err);
    logic [7:0] b4, b5, cs;
    b4 = is_ack ? code : seq_m;
    if (!is_ack) seq_m = seq_m + 8'd1;
    b5 = {switch, power_on_a, power_on_b, reset_a_signal, reset_b_signal,
          is_ack & err, is_ack, 1'b0};
    cs = 8'h00 - (8'hAB + b4 + b5);
    exp_q.push_back(8'hEB); exp_q.push_back(8'h90); exp_q.push_back(cs);
    exp_q.push_back(8'hAB); exp_q.push_back(b4);    exp_q.push_back(b5);
    exp_q.push_back(8'h09); exp_q.push_back(8'hD7);
  endfunction

  // Compare process: every cycle out of reset.
  int         byte_idx = 0;
  logic [7:0] last_tdr = '0;
  logic       prev_push = 1'b0;
  int         last7 = -100;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      byte_idx = 0; last_tdr = '0; prev_push = 1'b0; last7 = -100;
    end else begin
      chk("frame_done_timing", 32'(frame_done), 32'(cyc == last7 + 2));
      if (frame_done) begin
        done_cnt++;
        done_cyc_q.push_back(cyc);
        chk("busy_at_done", 32'(busy), 32'd1);
      end
      if (tf_push) begin
        chk("push_spacing", 32'(prev_push), 32'd0);
        chk("push_fifo_room", 32'(tf_counter < 5'd16), 32'd1);
        chk("busy_at_push", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_push: tdr=%0h with no frame expected (cycle %0d)", tdr, cyc);
        end else begin
          chk("tdr_byte", 32'(tdr), 32'(exp_q.pop_front()));
        end
        got_q.push_back(tdr);
        push_cyc_q.push_back(cyc);
        push_cnt++;
        if (byte_idx == 7) last7 = cyc;
        byte_idx = (byte_idx + 1) % 8;
        last_tdr = tdr;
      end else begin
        chk("tdr_hold", 32'(tdr), 32'(last_tdr));
      end
      prev_push = tf_push;
    end
  end

  task automatic drive_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_pushes(input int target, input int budget);
    int n = 0;
    while (push_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
    chk("push_wait_budget", 32'(push_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
    chk("done_wait_budget", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic pulse_ack(input logic [7:0] code, input bit err);
    ack_req = 1'b1; ack_code = code; ack_err = err;
    drive_cycle();
    ack_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1_lit[8];
  logic [7:0] t2_lit[8];
  int t0, tgt, base, prev_start;

  initial begin
    t1_lit = '{8'hEB, 8'h90, 8'hE9, 8'hAB, 8'h0A, 8'h62, 8'h09, 8'hD7};
    t2_lit = '{8'hEB, 8'h90, 8'h95, 8'hAB, 8'h00, 8'hC0, 8'h09, 8'hD7};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tf_push", 32'(tf_push), 32'd0);
    chk("rst_tdr", 32'(tdr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    drive_cycle(); drive_cycle();

    // 1: single ack frame, literal bytes and timing
    switch = 0; power_on_a = 1; power_on_b = 1; reset_a_signal = 0; reset_b_signal = 0;
    got_q.delete(); push_cyc_q.delete(); done_cyc_q.delete();
    exp_frame(1'b1, 8'h0A, 1'b0);
    tgt = done_cnt + 1;
    t0 = cyc;
    pulse_ack(8'h0A, 1'b0);
    wait_done(tgt, 40);
    chk("t1_push_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("t1_literal_byte", 32'(got_q[i]), 32'(t1_lit[i]));
    if (push_cyc_q.size() == 8) begin
      chk("t1_first_push_latency", 32'(push_cyc_q[0] - t0), 32'd3);
      for (int i = 1; i < 8; i++) chk("t1_push_gap", 32'(push_cyc_q[i] - push_cyc_q[i-1]), 32'd2);
    end
    if (done_cyc_q.size() > 0) chk("t1_req_to_done", 32'(done_cyc_q[0] - t0), 32'd19);

    // 3: FIFO full during byte 3
    repeat (3) drive_cycle();
    got_q.delete();
    base = push_cnt;
    tgt = done_cnt + 1;
    exp_frame(1'b1, 8'h5C, 1'b1);
    pulse_ack(8'h5C, 1'b1);
    wait_pushes(base + 3, 40);
    drive_cycle();
    tf_counter = 5'd16;
    repeat (10) drive_cycle();
    chk("t3_no_push_while_full", 32'(push_cnt), 32'(base + 3));
    tf_counter = 5'd15;
    @(negedge clk); #1;
    chk("t3_resume_same_cycle", 32'(push_cnt), 32'(base + 4));
    drive_cycle();
    tf_counter = 5'd0;
    wait_done(tgt, 60);
    chk("t3_push_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) chk("t3_byte3_literal", 32'(got_q[3]), 32'h0AB);

    // 5: ack overwrite while a frame is in flight; status change mid-frame
    repeat (3) drive_cycle();
    got_q.delete();
    base = push_cnt;
    tgt = done_cnt + 2;
    exp_frame(1'b1, 8'h33, 1'b0);
    pulse_ack(8'h33, 1'b0);
    wait_pushes(base + 2, 40);
    drive_cycle();
    switch = 1'b1;
    pulse_ack(8'h11, 1'b0);
    repeat (4) drive_cycle();
    exp_frame(1'b1, 8'h22, 1'b1);
    pulse_ack(8'h22, 1'b1);
    wait_done(tgt, 80);
    repeat (30) drive_cycle();
    chk("t5_single_follow_frame", 32'(done_cnt), 32'(tgt));
    chk("t5_push_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      chk("t5_b5_inflight_literal", 32'(got_q[5]), 32'h062);
      chk("t5_b4_latest_literal", 32'(got_q[12]), 32'h022);
      chk("t5_b5_new_status_literal", 32'(got_q[13]), 32'h0E6);
    end

    // 2: heartbeats, literal first frame, seq increment and wrap
    switch = 1; power_on_a = 1; power_on_b = 0;
    drive_cycle();
    hb_en = 1'b1;
    prev_start = 0;
    for (int i = 0; i < 257; i++) begin
      got_q.delete(); push_cyc_q.delete();
      exp_frame(1'b0, 8'h00, 1'b0);
      tgt = done_cnt + 1;
      wait_done(tgt, 100);
      if (i == 0)
        for (int j = 0; j < 8 && j < got_q.size(); j++) chk("t2_first_hb_literal", 32'(got_q[j]), 32'(t2_lit[j]));
      if (got_q.size() == 8) begin
        if (i == 1)   chk("t2_seq_01", 32'(got_q[4]), 32'h001);
        if (i == 255) chk("t2_seq_ff", 32'(got_q[4]), 32'h0FF);
        if (i == 256) chk("t2_seq_wrap_00", 32'(got_q[4]), 32'h000);
      end
      if (push_cyc_q.size() > 0) begin
        if (i == 2) chk("t2_hb_period", 32'(push_cyc_q[0] - prev_start), 32'd64);
        prev_start = push_cyc_q[0];
      end
    end
    drive_cycle();
    hb_en = 1'b0;

    // 4: ack and heartbeat pending on the same edge -> ack first, hb right after
    repeat (5) drive_cycle();
    got_q.delete(); push_cyc_q.delete(); done_cyc_q.delete();
    tgt = done_cnt + 2;
    exp_frame(1'b1, 8'h7E, 1'b0);
    exp_frame(1'b0, 8'h00, 1'b0);
    hb_en = 1'b1;
    repeat (63) drive_cycle();
    pulse_ack(8'h7E, 1'b0);
    wait_done(tgt, 80);
    drive_cycle();
    hb_en = 1'b0;
    chk("t4_push_count", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      chk("t4_ack_first_literal", 32'(got_q[4]), 32'h07E);
      chk("t4_hb_seq_literal", 32'(got_q[12]), 32'h001);
    end
    if (push_cyc_q.size() == 16 && done_cyc_q.size() >= 1)
      chk("t4_hb_immediately_after", 32'(push_cyc_q[8] - done_cyc_q[0]), 32'd3);

    // 6: reset mid-frame
    repeat (3) drive_cycle();
    base = push_cnt;
    exp_frame(1'b1, 8'h5A, 1'b0);
    pulse_ack(8'h5A, 1'b0);
    wait_pushes(base + 5, 40);
    @(posedge clk); #1;
    ack_req = 1'b1; ack_code = 8'h44; ack_err = 1'b0;
    @(posedge clk); #1;
    ack_req = 1'b0;
    #2;
    chk("t6_push_before_reset", 32'(tf_push), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    seq_m = '0;
    #1;
    chk("t6_async_tf_push", 32'(tf_push), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_frame_done", 32'(frame_done), 32'd0);
    chk("t6_async_tdr", 32'(tdr), 32'd0);
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b1;
    base = push_cnt;
    tgt = done_cnt;
    repeat (40) drive_cycle();
    chk("t6_idle_after_reset", 32'(busy), 32'd0);
    chk("t6_no_resume_pushes", 32'(push_cnt), 32'(base));
    chk("t6_no_pending_frame", 32'(done_cnt), 32'(tgt));
    got_q.delete();
    exp_frame(1'b0, 8'h00, 1'b0);
    tgt = done_cnt + 1;
    hb_en = 1'b1;
    wait_done(tgt, 100);
    drive_cycle();
    hb_en = 1'b0;
    if (got_q.size() == 8) begin
      chk("t6_seq_reset_literal", 32'(got_q[4]), 32'h000);
      chk("t6_cs_literal", 32'(got_q[2]), 32'h095);
    end else begin
      chk("t6_hb_push_count", 32'(got_q.size()), 32'd8);
    end

    repeat (5) drive_cycle();
    chk("all_expected_bytes_sent", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
